// File: rtl/tt_um_ha_pkg.sv
// tt_um_ha_pkg: shared mode encodings, widths and constants for tt_um_ha
package tt_um_ha_pkg;
  typedef enum logic [1:0] {
    MODE_BITWISE = 2'b00,
    MODE_ADD     = 2'b01,
    MODE_ACC     = 2'b10,
    MODE_POP     = 2'b11
  } mode_e;
  localparam int OP_W = 4;
  localparam int ACC_W = 8;
  localparam logic [7:0] UIO_OE = 8'hF0;
endpackage

// File: rtl/ha_cell.sv
// ha_cell: single-bit half adder, the building block of every datapath in tt_um_ha
module ha_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/tt_um_ha.sv
// tt_um_ha: half-adder ALU with bitwise, ripple add and popcount modes, registered outputs.
// Defining HA_ACCUM_EN adds the 8-bit accumulator (mode 10, acc_clear); rst_n is active-high.
module tt_um_ha
  import tt_um_ha_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [OP_W-1:0] w_a, w_b, w_xor, w_and, w_add_sum, w_add_s1, w_add_c1, w_add_c2;
  logic [OP_W:0] w_add_c;
  logic [3:0][1:0] w_p1;
  logic [1:0][2:0] w_p2;
  logic [2:0] w_p3_s1, w_p3_c1, w_p3_c2;
  logic [3:0] w_p3_c, w_pop;
  logic [ACC_W-1:0] w_res, w_acc_res, r_out;
  logic w_cf, w_acc_cf, r_cf, r_zf, w_unused;
  logic [1:0] r_mode;
  mode_e w_mode;
  assign w_a = ui_in[OP_W-1:0];
  assign w_b = ui_in[7:OP_W];
  assign w_mode = mode_e'(uio_in[1:0]);
  assign w_unused = ^uio_in[7:2];
  for (genvar i = 0; i < OP_W; i++) begin : g_bit
    ha_cell u_bw (.a(w_a[i]), .b(w_b[i]), .sum(w_xor[i]), .carry(w_and[i]));
  end
  // Ripple add: each bit is a half-adder pair, the two carries ORed into the next stage
  assign w_add_c[0] = 1'b0;
  for (genvar i = 0; i < OP_W; i++) begin : g_add
    ha_cell u_h0 (.a(w_a[i]), .b(w_b[i]), .sum(w_add_s1[i]), .carry(w_add_c1[i]));
    ha_cell u_h1 (.a(w_add_s1[i]), .b(w_add_c[i]), .sum(w_add_sum[i]), .carry(w_add_c2[i]));
    assign w_add_c[i+1] = w_add_c1[i] | w_add_c2[i];
  end
  // Popcount tree: bit pairs -> 2-bit counts -> 3-bit counts -> 4-bit total
  for (genvar i = 0; i < 4; i++) begin : g_p1
    ha_cell u_h (.a(ui_in[2*i]), .b(ui_in[2*i+1]), .sum(w_p1[i][0]), .carry(w_p1[i][1]));
  end
  for (genvar j = 0; j < 2; j++) begin : g_p2
    logic [1:0] w_s1, w_c1, w_c2;
    logic [2:0] w_c;
    assign w_c[0] = 1'b0;
    for (genvar i = 0; i < 2; i++) begin : g_b
      ha_cell u_h0 (.a(w_p1[2*j][i]), .b(w_p1[2*j+1][i]), .sum(w_s1[i]), .carry(w_c1[i]));
      ha_cell u_h1 (.a(w_s1[i]), .b(w_c[i]), .sum(w_p2[j][i]), .carry(w_c2[i]));
      assign w_c[i+1] = w_c1[i] | w_c2[i];
    end
    assign w_p2[j][2] = w_c[2];
  end
  assign w_p3_c[0] = 1'b0;
  for (genvar i = 0; i < 3; i++) begin : g_p3
    ha_cell u_h0 (.a(w_p2[0][i]), .b(w_p2[1][i]), .sum(w_p3_s1[i]), .carry(w_p3_c1[i]));
    ha_cell u_h1 (.a(w_p3_s1[i]), .b(w_p3_c[i]), .sum(w_pop[i]), .carry(w_p3_c2[i]));
    assign w_p3_c[i+1] = w_p3_c1[i] | w_p3_c2[i];
  end
  assign w_pop[3] = w_p3_c[3];
`ifdef HA_ACCUM_EN
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W:0] w_acc_sum;
  logic w_clr;
  assign w_clr = uio_in[2];
  assign w_acc_sum = {1'b0, r_acc} + {{(ACC_W-OP_W+1){1'b0}}, w_a};
  assign w_acc_res = w_clr ? '0 : w_acc_sum[ACC_W-1:0];
  assign w_acc_cf = w_clr ? 1'b0 : w_acc_sum[ACC_W];
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) r_acc <= '0;
    else if (ena) r_acc <= w_clr ? '0 : (w_mode == MODE_ACC) ? w_acc_sum[ACC_W-1:0] : r_acc;
`else
  assign w_acc_res = '0;
  assign w_acc_cf = 1'b0;
`endif
  always_comb begin
    w_res = '0;
    w_cf = 1'b0;
    case (w_mode)
      MODE_BITWISE: begin
        w_res = {w_and, w_xor};
        w_cf = |w_and;
      end
      MODE_ADD: begin
        w_res = {3'b000, w_add_c[OP_W], w_add_sum};
        w_cf = w_add_c[OP_W];
      end
      MODE_ACC: begin
        w_res = w_acc_res;
        w_cf = w_acc_cf;
      end
      default: w_res = {4'b0000, w_pop};
    endcase
  end
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      r_out <= '0;
      r_mode <= '0;
      r_zf <= 1'b0;
      r_cf <= 1'b0;
    end else if (ena) begin
      r_out <= w_res;
      r_mode <= uio_in[1:0];
      r_zf <= (w_res == '0);
      r_cf <= w_cf;
    end
  assign uo_out = r_out;
  assign uio_out = {r_mode, r_zf, r_cf, 4'b0000};
  assign uio_oe = UIO_OE;
endmodule

// File: tb/tb_tt_um_ha.sv
// tb_tt_um_ha: scoreboard bench for tt_um_ha; accumulator vectors apply when HA_ACCUM_EN is defined
module tb_tt_um_ha;
  logic clk = 1'b0;
  logic rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  logic [15:0] exp_q[$];
  string nm_q[$];
  int errors = 0;
  int checks = 0;
  tt_um_ha dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] st(input logic [1:0] m, input logic [7:0] o, input logic c);
    return {m, o == 8'h00, c, 4'h0};
  endfunction
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask
  task automatic apply(input logic e, input logic [7:0] ui, input logic [7:0] ctl,
                       input logic [7:0] eo, input logic [7:0] eu, input string nm);
    @(negedge clk);
    ena = e;
    ui_in = ui;
    uio_in = ctl;
    exp_q.push_back({eo, eu});
    nm_q.push_back(nm);
  endtask
  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses never checked, want 0", exp_q.size());
      exp_q.delete();
      nm_q.delete();
    end
  endtask
  initial forever begin
    logic [15:0] e;
    string n;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      checks++;
      if ({uo_out, uio_out} !== e) begin
        errors++;
        $display("FAIL %s: got uo_out=%h uio_out=%h want uo_out=%h uio_out=%h",
                 n, uo_out, uio_out, e[15:8], e[7:0]);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
`ifdef HA_ACCUM_EN
    logic [8:0] s;
    logic [7:0] acc_m;
`endif
    rst_n = 1'b1;
    ena = 1'b1;
    ui_in = 8'h5A;
    uio_in = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_uo_out", uo_out, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("uio_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b0;
    apply(1, 8'hAC, 8'h00, 8'h86, st(2'b00, 8'h86, 1), "bitwise_c_a");
    apply(1, 8'h0F, 8'h00, 8'h0F, st(2'b00, 8'h0F, 0), "bitwise_f_0");
    apply(1, 8'h89, 8'h01, 8'h11, st(2'b01, 8'h11, 1), "add_9_8");
    apply(1, 8'h00, 8'h01, 8'h00, st(2'b01, 8'h00, 0), "add_0_0");
    apply(1, 8'h57, 8'hF9, 8'h0C, st(2'b01, 8'h0C, 0), "add_7_5");
    apply(1, 8'hFF, 8'h03, 8'h08, st(2'b11, 8'h08, 0), "pop_ff");
    apply(1, 8'h81, 8'h03, 8'h02, st(2'b11, 8'h02, 0), "pop_81");
    apply(1, 8'h00, 8'h03, 8'h00, st(2'b11, 8'h00, 0), "pop_00");
    apply(1, 8'hB6, 8'h03, 8'h05, st(2'b11, 8'h05, 0), "pop_b6");
    apply(1, 8'h57, 8'h01, 8'h0C, st(2'b01, 8'h0C, 0), "ena_pre");
    apply(0, 8'hAC, 8'h00, 8'h0C, st(2'b01, 8'h0C, 0), "ena_hold0");
    apply(0, 8'hFF, 8'h03, 8'h0C, st(2'b01, 8'h0C, 0), "ena_hold1");
    apply(0, 8'h0F, 8'h06, 8'h0C, st(2'b01, 8'h0C, 0), "ena_hold2");
    apply(1, 8'hAC, 8'h00, 8'h86, st(2'b00, 8'h86, 1), "ena_resume");
`ifdef HA_ACCUM_EN
    apply(1, 8'h0F, 8'h06, 8'h00, st(2'b10, 8'h00, 0), "acc_clear0");
    acc_m = 8'h00;
    for (int k = 1; k <= 18; k++) begin
      s = {1'b0, acc_m} + 9'd15;
      acc_m = s[7:0];
      apply(1, 8'h0F, 8'h02, s[7:0], st(2'b10, s[7:0], s[8]), $sformatf("acc_step%0d", k));
    end
    apply(1, 8'h0F, 8'h06, 8'h00, st(2'b10, 8'h00, 0), "acc_clear1");
    apply(1, 8'h05, 8'h02, 8'h05, st(2'b10, 8'h05, 0), "acc_5");
    apply(1, 8'h05, 8'h02, 8'h0A, st(2'b10, 8'h0A, 0), "acc_10");
    apply(1, 8'h21, 8'h01, 8'h03, st(2'b01, 8'h03, 0), "acc_away_add");
    apply(1, 8'h05, 8'h02, 8'h0F, st(2'b10, 8'h0F, 0), "acc_resume");
    apply(1, 8'h11, 8'h05, 8'h02, st(2'b01, 8'h02, 0), "clear_in_add");
    apply(1, 8'h03, 8'h02, 8'h03, st(2'b10, 8'h03, 0), "acc_after_clr");
    apply(0, 8'h0F, 8'h02, 8'h03, st(2'b10, 8'h03, 0), "acc_hold0");
    apply(0, 8'h0F, 8'h06, 8'h03, st(2'b10, 8'h03, 0), "acc_hold1");
    apply(0, 8'h0F, 8'h02, 8'h03, st(2'b10, 8'h03, 0), "acc_hold2");
    apply(1, 8'h01, 8'h02, 8'h04, st(2'b10, 8'h04, 0), "acc_after_hold");
`else
    apply(1, 8'h0F, 8'h02, 8'h00, st(2'b10, 8'h00, 0), "noacc_mode10");
    apply(1, 8'h0F, 8'h06, 8'h00, st(2'b10, 8'h00, 0), "noacc_clear");
    apply(1, 8'h89, 8'h01, 8'h11, st(2'b01, 8'h11, 1), "add_before_rst");
`endif
    drain();
    #3;
    rst_n = 1'b1;
    #1;
    chk("midrst_uo_out", uo_out, 8'h00);
    chk("midrst_uio_out", uio_out, 8'h00);
    @(negedge clk);
    ena = 1'b1;
    ui_in = 8'h89;
    uio_in = 8'h05;
    @(posedge clk);
    #1;
    chk("rst_over_ena_uo", uo_out, 8'h00);
    chk("rst_over_ena_uio", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    apply(1, 8'h00, 8'h02, 8'h00, st(2'b10, 8'h00, 0), "acc_after_rst");
    apply(1, 8'hAC, 8'h00, 8'h86, st(2'b00, 8'h86, 1), "bitwise_after_rst");
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tt_um_ha.md
TT_UM_HA -- requirements
Module: tt_um_ha

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous reset, active-high (asserted at 1), despite the _n suffix.
REQ-003 SHALL have port: ena  input  1  enable; 0 freezes all registers.
REQ-004 SHALL have port: ui_in  input  8  operands.
  - A = ui_in[3:0]
  - B = ui_in[7:4]
REQ-005 SHALL have port: uio_in  input  8  control.
  - uio_in[1:0] = mode
  - uio_in[2] = acc_clear
  - uio_in[7:3] ignored
REQ-006 SHALL have port: uo_out  output  8  registered result.
REQ-007 SHALL have port: uio_out  output  8  status.
  - [7:6] mode echo, [5] zero flag, [4] carry flag
  - [3:0] constant 0
REQ-008 SHALL drive uio_oe  output  8  constant 8'hF0.

Function
REQ-009 SHALL register uo_out and uio_out[7:4], with 1-cycle latency: outputs reflect inputs sampled at the previous rising edge where ena=1.
REQ-010 SHALL compute mode 00 (BITWISE) per bit via half-adder cells: uo_out[3:0]=A^B, uo_out[7:4]=A&B; carry flag = |(A&B).
REQ-011 SHALL compute mode 01 (ADD) as a 4-bit ripple add built from half-adder pairs:
  - uo_out[3:0] = (A+B) mod 16
  - uo_out[4] = carry-out, also copied to the carry flag
  - uo_out[7:5] = 0
REQ-012 SHALL compute mode 10 (ACC) on an 8-bit accumulator: acc <= acc + {4'b0,A} mod 256.
  - uo_out = updated acc
  - carry flag = carry-out of that addition (255+1 -> acc 0, carry 1)
REQ-013 SHALL clear acc to 0 when acc_clear=1 and ena=1, in any mode.
  - Clear takes priority over accumulate.
  - In mode 10 the same cycle yields uo_out=0, carry 0.
REQ-014 SHALL compute mode 11 (POPCOUNT): uo_out[3:0] = number of 1s in ui_in (0..8) via a half/full-adder tree; uo_out[7:4]=0; carry flag 0.
REQ-015 SHALL keep acc unchanged outside mode 10 (except clear), so returning to mode 10 resumes from the held value.
REQ-016 SHALL set zero flag = 1 iff the registered uo_out value is 8'h00.
REQ-017 SHALL register the mode echo uio_out[7:6] with the same latency as uo_out.
REQ-018 SHALL take effect on the next enabled edge after a mid-stream mode change, with no stale cross-mode data.

Reset
REQ-019 SHALL, while rst_n=1, asynchronously force:
  - uo_out=0
  - uio_out=0 (zero flag included)
  - acc=0
REQ-020 SHALL resume normal operation on the first rising edge after rst_n deasserts, when ena=1.
REQ-021 SHALL let reset override ena and acc_clear.

Configuration
REQ-022 SHALL include the accumulator (acc register, mode 10, acc_clear) when macro HA_ACCUM_EN is defined.
REQ-023 SHALL behave as follows without HA_ACCUM_EN:
  - No acc register is built.
  - Mode 10 yields uo_out=0, carry 0, zero flag 1.
  - acc_clear is ignored.

Structure
REQ-024 SHALL place in shared package tt_um_ha_pkg:
  - mode encodings (MODE_BITWISE=2'b00, MODE_ADD=2'b01, MODE_ACC=2'b10, MODE_POP=2'b11)
  - operand width (4), accumulator width (8)
  - UIO_OE constant 8'hF0
REQ-025 SHALL implement the half adder as sub-module ha_cell (a, b -> sum, carry), instantiated for all bitwise, ripple and popcount logic.

Verification
REQ-026 SHALL cover reset: assert rst_n=1 mid-stream with nonzero acc -> uo_out=0, uio_out=0 immediately; acc reads 0 in next mode-10 cycle with A=0.
REQ-027 SHALL cover mode 00: A=4'b1100, B=4'b1010 -> uo_out=8'h86, carry flag 1.
REQ-028 SHALL cover mode 01: A=9, B=8 -> uo_out=8'h11, carry 1; A=0, B=0 -> uo_out=0, zero flag 1.
REQ-029 SHALL cover mode 10, all with A=15:
  - 17 accumulates from 0 -> 15,30,...,255, then wraps to 14 with carry 1
  - acc_clear=1 -> uo_out=0
REQ-030 SHALL cover mode 11: ui_in=8'hFF -> uo_out=8; ui_in=8'h81 -> 2; ui_in=0 -> 0 with zero flag 1.
REQ-031 SHALL cover ena: ena=0 for 3 cycles with changing inputs -> outputs and acc hold; ena=1 -> update after 1 cycle.
